spectrum_peak_reader: RTL and testbench

Consumer end of the FFT magnitude read-out handshake. After each FFT frame it drives the bin `index`, captures every `magnitude`/`magnitude_ready` pulse for bins 0..NUM_BINS-1, and keeps the per-band maximum over fixed fingerprint bands. At frame end it streams one peak record per band to the fingerprint hasher over a valid/ready interface.

---
 rtl/spectrum_pkg.sv | 23 ++
 rtl/band_lookup.sv | 16 +
 rtl/spectrum_peak_reader.sv | 123 ++++++++++++
 tb/tb_spectrum_peak_reader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared types and band map for the FFT spectrum peak reader.
// A bin belongs to the highest band whose start it reaches.
package spectrum_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } reader_state_t;

   localparam int NUM_BANDS = 6;
   localparam logic [10:0] BAND_START [NUM_BANDS] =
      '{11'd0, 11'd10, 11'd20, 11'd40, 11'd80, 11'd160};

   localparam int REC_MAG_W = 16;

   typedef struct packed {
      logic [2:0]           band;
      logic [10:0]          bin;
      logic [REC_MAG_W-1:0] mag;
   } peak_rec_t;

endpackage

// File: rtl/band_lookup.sv
// Combinational map from FFT bin index to fingerprint band number.
module band_lookup
   import spectrum_pkg::*;
(
   input  logic [10:0] index,
   output logic [2:0]  band
);

   always_comb begin
      band = 3'd0;
      for (int i = 1; i < NUM_BANDS; i++) begin
         if (index >= BAND_START[i]) band = 3'(i);
      end
   end

endmodule

// File: rtl/spectrum_peak_reader.sv
// Reads one FFT frame of magnitudes bin by bin, tracks the per-band maximum,
// then streams one peak record per band. Handshake: a record moves on peak_valid & peak_ready.
module spectrum_peak_reader
   import spectrum_pkg::*;
#(
   parameter int NUM_BINS = 512,
   parameter int MAG_DW   = 16,
   parameter int FRAME_W  = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               done_fft,
   output logic [10:0]        index,
   input  logic [MAG_DW-1:0]  magnitude,
   input  logic               magnitude_ready,
   output logic               peak_valid,
   input  logic               peak_ready,
   output logic [2:0]         peak_band,
   output logic [10:0]        peak_bin,
   output logic [MAG_DW-1:0]  peak_mag,
   output logic [FRAME_W-1:0] peak_frame,
   output logic               peak_last,
   output logic               frame_dropped,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   localparam logic [10:0] LAST_BIN = 11'(NUM_BINS - 1);

   reader_state_t     state;
   logic              done_q;
   logic              done_rise;
   logic [2:0]        cur_band;
   logic [2:0]        next_band;
   logic [MAG_DW-1:0] band_max [NUM_BANDS];
   logic [10:0]       band_bin [NUM_BANDS];

   band_lookup u_band_lookup (
      .index (index),
      .band  (cur_band)
   );

   assign done_rise = done_fft & ~done_q;
   assign next_band = peak_band + 3'd1;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         done_q        <= 1'b0;
         index         <= '0;
         peak_valid    <= 1'b0;
         peak_band     <= '0;
         peak_bin      <= '0;
         peak_mag      <= '0;
         peak_frame    <= '0;
         peak_last     <= 1'b0;
         frame_dropped <= 1'b0;
         busy          <= 1'b0;
         for (int i = 0; i < NUM_BANDS; i++) begin
            band_max[i] <= '0;
            band_bin[i] <= '0;
         end
      end else begin
         done_q        <= done_fft;
         frame_dropped <= done_rise && (state != IDLE);
         case (state)
            IDLE: begin
               if (done_rise) begin
                  for (int i = 0; i < NUM_BANDS; i++) begin
                     band_max[i] <= '0;
                     band_bin[i] <= BAND_START[i];
                  end
                  state <= COLLECT;
                  busy  <= 1'b1;
               end
            end
            COLLECT: begin
               if (magnitude_ready) begin
                  // Strict compare: on a tie the earlier (lower) bin is kept.
                  if (magnitude > band_max[cur_band]) begin
                     band_max[cur_band] <= magnitude;
                     band_bin[cur_band] <= index;
                  end
                  // Band 0 cannot be written on the final strobe, so it is safe to load now.
                  if (index == LAST_BIN) begin
                     state      <= EMIT;
                     peak_valid <= 1'b1;
                     peak_band  <= 3'd0;
                     peak_bin   <= band_bin[0];
                     peak_mag   <= band_max[0];
                     peak_last  <= 1'b0;
                  end else begin
                     index <= index + 11'd1;
                  end
               end
            end
            EMIT: begin
               if (peak_valid && peak_ready) begin
                  if (peak_band == 3'(NUM_BANDS - 1)) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     peak_valid <= 1'b0;
                     peak_last  <= 1'b0;
                     peak_band  <= '0;
                     peak_bin   <= '0;
                     peak_mag   <= '0;
                     index      <= '0;
                     peak_frame <= peak_frame + FRAME_W'(1);
                  end else begin
                     peak_band <= next_band;
                     peak_bin  <= band_bin[next_band];
                     peak_mag  <= band_max[next_band];
                     peak_last <= (peak_band == 3'(NUM_BANDS - 2));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spectrum_peak_reader.sv
// Bench for spectrum_peak_reader: table-driven frames, a random-data model,
// and hand-written backpressure, overrun and mid-frame reset sequences.
module tb_spectrum_peak_reader;
   import spectrum_pkg::*;

   localparam int NUM_BINS = 512;
   localparam int MAG_DW   = 16;
   localparam int FRAME_W  = 16;
   localparam int REC_W    = 3 + 11 + MAG_DW + FRAME_W + 1;
   localparam int TB_START [6] = '{0, 10, 20, 40, 80, 160};
   localparam int TB_END   [6] = '{9, 19, 39, 79, 159, NUM_BINS - 1};

   logic               clk;
   logic               reset_n;
   logic               done_fft;
   logic [10:0]        index;
   logic [MAG_DW-1:0]  magnitude;
   logic               magnitude_ready;
   logic               peak_valid;
   logic               peak_ready;
   logic [2:0]         peak_band;
   logic [10:0]        peak_bin;
   logic [MAG_DW-1:0]  peak_mag;
   logic [FRAME_W-1:0] peak_frame;
   logic               peak_last;
   logic               frame_dropped;
   logic               busy;
   logic [1:0]         dbg_state;

   int checks = 0;
   int passed = 0;
   int frame_no = 0;
   int rdy_mode = 0;
   logic manual_ready = 1'b0;
   logic [REC_W-1:0] exp_q[$];
   logic [15:0] mags [NUM_BINS];

   typedef struct packed {
      logic [1:0]        mode;
      logic [15:0]       param;
      logic [5:0][10:0]  exp_bin;
      logic [5:0][15:0]  exp_mag;
   } vec_t;
   vec_t vecs [4];

   spectrum_peak_reader #(
      .NUM_BINS (NUM_BINS),
      .MAG_DW   (MAG_DW),
      .FRAME_W  (FRAME_W)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .done_fft        (done_fft),
      .index           (index),
      .magnitude       (magnitude),
      .magnitude_ready (magnitude_ready),
      .peak_valid      (peak_valid),
      .peak_ready      (peak_ready),
      .peak_band       (peak_band),
      .peak_bin        (peak_bin),
      .peak_mag        (peak_mag),
      .peak_frame      (peak_frame),
      .peak_last       (peak_last),
      .frame_dropped   (frame_dropped),
      .busy            (busy),
      .dbg_state       (dbg_state)
   );

   // clock / reset / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ready driver, offset from the main process so manual_ready is settled
   initial begin
      peak_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       peak_ready = 1'b1;
            1:       peak_ready = ($urandom_range(0, 3) != 0);
            default: peak_ready = manual_ready;
         endcase
      end
   end

   // scoreboard: pop on every accepted record
   always @(negedge clk) begin
      if (reset_n && peak_valid && peak_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_record: got band %0d bin %0d with none expected", peak_band, peak_bin);
         end else begin
            check("record", {peak_band, peak_bin, peak_mag, peak_frame, peak_last}, exp_q.pop_front());
         end
      end
   end

   task automatic push_rec(input int band, input int bin, input int mag);
      peak_rec_t r;
      r.band = 3'(band);
      r.bin  = 11'(bin);
      r.mag  = 16'(mag);
      exp_q.push_back({r, 16'(frame_no), (band == 5)});
   endtask

   task automatic fill_table(input int i);
      for (int b = 0; b < NUM_BINS; b++) begin
         case (vecs[i].mode)
            2'd0:    mags[b] = 16'(b);
            2'd1:    mags[b] = vecs[i].param;
            2'd2:    mags[b] = 16'(1000 - b);
            default: mags[b] = (b == int'(vecs[i].param)) ? 16'd60000 : 16'(b % 7);
         endcase
      end
      for (int k = 0; k < 6; k++) push_rec(k, vecs[i].exp_bin[k], vecs[i].exp_mag[k]);
   endtask

   task automatic fill_random();
      int m;
      int bn;
      for (int b = 0; b < NUM_BINS; b++) mags[b] = 16'($urandom_range(0, 200));
      for (int k = 0; k < 6; k++) begin
         m  = 0;
         bn = TB_START[k];
         for (int b = TB_START[k]; b <= TB_END[k]; b++) begin
            if (int'(mags[b]) > m) begin
               m  = mags[b];
               bn = b;
            end
         end
         push_rec(k, bn, m);
      end
   endtask

   task automatic run_frame(input int ovr_at, input int abort_at, input bit manual);
      int n;
      logic [30:0] snap;
      check("busy_before_edge", busy, 1'b0);
      done_fft = 1'b1;
      tick();
      check("busy_after_edge", busy, 1'b1);
      check("state_collect", dbg_state, COLLECT);
      for (int b = 0; b < NUM_BINS; b++) begin
         if (b == abort_at) begin
            check("abort_index", index, b);
            reset_n  = 1'b0;
            done_fft = 1'b0;
            #1;
            check("abort_index0", index, 0);
            check("abort_busy0", busy, 1'b0);
            check("abort_valid0", peak_valid, 1'b0);
            check("abort_frame0", peak_frame, 0);
            check("abort_rec0", {peak_band, peak_bin, peak_mag, peak_last, frame_dropped}, 0);
            exp_q.delete();
            frame_no = 0;
            tick();
            reset_n = 1'b1;
            tick();
            return;
         end
         if (b == ovr_at) begin
            done_fft = 1'b0;
            tick();
            done_fft = 1'b1;
            tick();
            check("frame_dropped_pulse", frame_dropped, 1'b1);
            tick();
            check("frame_dropped_clear", frame_dropped, 1'b0);
         end
         if (b % 64 == 0 || b == NUM_BINS - 1) check("index", index, b);
         magnitude       = mags[b];
         magnitude_ready = 1'b1;
         tick();
         magnitude_ready = 1'b0;
         if (b != NUM_BINS - 1) repeat ($urandom_range(0, 1)) tick();
      end
      check("valid_after_last", peak_valid, 1'b1);
      check("index_held", index, NUM_BINS - 1);
      if (!manual) begin
         n = 0;
         while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
         end
         check("emit_done", busy, 1'b0);
         if (rdy_mode == 0) check("emit_cycles", n, 6);
      end else begin
         for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
               snap = {peak_valid, peak_band, peak_bin, peak_mag};
               for (int c = 0; c < 5; c++) begin
                  magnitude       = 16'hFFFF;
                  magnitude_ready = (c % 2 == 0);
                  tick();
                  check("bp_hold_stable", {peak_valid, peak_band, peak_bin, peak_mag}, snap);
                  check("bp_busy", busy, 1'b1);
                  check("bp_index", index, NUM_BINS - 1);
               end
               magnitude_ready = 1'b0;
            end
            manual_ready = 1'b1;
            tick();
            manual_ready = 1'b0;
            check("bp_busy_after", busy, (k != 5));
            tick();
         end
      end
      check("idle_index0", index, 0);
      check("idle_valid0", peak_valid, 1'b0);
      frame_no++;
      tick();
      tick();
      check("no_retrigger", busy, 1'b0);
      done_fft = 1'b0;
      tick();
   endtask

   initial begin
      reset_n         = 1'b0;
      done_fft        = 1'b0;
      magnitude       = '0;
      magnitude_ready = 1'b0;

      vecs[0].mode = 2'd0;  vecs[0].param = 16'd0;
      vecs[0].exp_bin = {11'd511, 11'd159, 11'd79, 11'd39, 11'd19, 11'd9};
      vecs[0].exp_mag = {16'd511, 16'd159, 16'd79, 16'd39, 16'd19, 16'd9};
      vecs[1].mode = 2'd1;  vecs[1].param = 16'd100;
      vecs[1].exp_bin = {11'd160, 11'd80, 11'd40, 11'd20, 11'd10, 11'd0};
      vecs[1].exp_mag = {16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100};
      vecs[2].mode = 2'd2;  vecs[2].param = 16'd0;
      vecs[2].exp_bin = {11'd160, 11'd80, 11'd40, 11'd20, 11'd10, 11'd0};
      vecs[2].exp_mag = {16'd840, 16'd920, 16'd960, 16'd980, 16'd990, 16'd1000};
      vecs[3].mode = 2'd3;  vecs[3].param = 16'd300;
      vecs[3].exp_bin = {11'd300, 11'd83, 11'd41, 11'd20, 11'd13, 11'd6};
      vecs[3].exp_mag = {16'd60000, 16'd6, 16'd6, 16'd6, 16'd6, 16'd6};

      repeat (3) tick();
      check("rst_index", index, 0);
      check("rst_valid", peak_valid, 1'b0);
      check("rst_rec", {peak_band, peak_bin, peak_mag, peak_frame, peak_last}, 0);
      check("rst_dropped", frame_dropped, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_state", dbg_state, IDLE);
      reset_n = 1'b1;
      tick();

      magnitude       = 16'hFFFF;
      magnitude_ready = 1'b1;
      tick();
      magnitude_ready = 1'b0;
      check("stray_idle_index", index, 0);
      check("stray_idle_busy", busy, 1'b0);

      rdy_mode = 0;
      for (int i = 0; i < 4; i++) begin
         fill_table(i);
         run_frame((i == 0) ? 300 : -1, -1, 1'b0);
      end

      rdy_mode     = 2;
      manual_ready = 1'b0;
      fill_random();
      run_frame(-1, -1, 1'b1);

      rdy_mode = 1;
      fill_random();
      run_frame(-1, -1, 1'b0);

      rdy_mode = 0;
      for (int b = 0; b < NUM_BINS; b++) mags[b] = 16'd5000;
      run_frame(-1, 200, 1'b0);
      fill_table(1);
      run_frame(-1, -1, 1'b0);

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
